bg_tile_fetcher: RTL
====================

// Module: bg_tile_fetcher
// PURPOSE
//  Background tile fetch sequencer fed by the two M67673 raster scrollers (H and V scrolled sums + carries).
//  Per 8-pixel group: reads tile code/attribute from VRAM, fetches one 32-bit pattern word, shifts out 4bpp pixels.
//  Fetches one group ahead of display. Output feeds the palette/priority mixer.
// PARAMETERS
//  ROM_AW    15   pattern ROM word address width: {code[9:0], row[3:0], half}
//  VRAM_AW   11   VRAM byte address width: {V[8:4], H[8:4], bytesel}
// PORTS
//  i_EMU_MCLK          in   1        master clock
//  i_EMU_INITRST_n     in   1        asynchronous active-low reset
//  i_EMU_CLK6MPCEN_n   in   1        pixel enable (active low), one MCLK wide
//  i_HSUM / i_HCARRY   in   8 / 1    scrolled horizontal position {carry,sum} = 9-bit H
//  i_VSUM / i_VCARRY   in   8 / 1    scrolled vertical position = 9-bit V
//  i_HBLANK_n          in   1        active-low horizontal blank
//  o_VRAM_ADDR         out  VRAM_AW  tile RAM byte address
//  i_VRAM_DATA         in   8        tile RAM read data, valid one pixel enable after address
//  o_ROM_RD            out  1        pattern ROM read request, held until accepted
//  o_ROM_ADDR          out  ROM_AW   pattern ROM word address, stable while o_ROM_RD=1
//  i_ROM_RDY           in   1        data-valid strobe, one MCLK, qualifies i_ROM_DATA
//  i_ROM_DATA          in   32       8 pixels x 4bpp, pixel 0 in [31:28]
//  o_PIXEL             out  4        colour index, 0 = transparent
//  o_PALETTE           out  4        palette bank of current pixel
//  o_UNDERRUN          out  1        sticky: a group boundary passed before its ROM data arrived
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, shifter/attr regs 0, o_UNDERRUN 0. Reset mid-fetch abandons request immediately.
//  Phase = i_HSUM[2:0]; all steps below occur on MCLK where i_EMU_CLK6MPCEN_n=0 unless stated.
//  Next-group H: NH = {i_HCARRY,i_HSUM} + 9'd8, 9-bit wrap (0x1FC+8 -> 0x004). V used as {i_VCARRY,i_VSUM}.
//  FSM: IDLE -> CODE -> ATTR -> REQ -> WAIT -> DONE -> IDLE.
//   phase 1 (any state): force CODE; o_VRAM_ADDR={V[8:4],NH[8:4],1'b0}. Resyncs after mid-line scroll jumps.
//   CODE, phase 2: latch code=i_VRAM_DATA; addr LSB<=1; -> ATTR.
//   ATTR, phase 3: latch attr; -> REQ. attr[7:6]=code[9:8], [5]=hflip, [4]=vflip, [3:0]=palette.
//   REQ: o_ROM_RD=1 next MCLK, o_ROM_ADDR={attr[7:6],code,row,NH[3]}; row=V[3:0] (^4'hF if vflip); -> WAIT.
//   WAIT: on i_ROM_RDY (any MCLK, ignores pixel enable) capture word, drop o_ROM_RD same edge; -> DONE.
//  Group boundary = pixel enable with phase 7: shifter<=buffered word, palette/flip regs<=pending, state->IDLE.
//   If state != DONE at boundary: shifter<=0, set o_UNDERRUN, withdraw o_ROM_RD; late i_ROM_RDY ignored.
//  Shifter: shifts 4 bits per pixel enable; o_PIXEL = [31:28], or [3:0] with reversed shift when hflip.
//  o_PIXEL/o_PALETTE registered, forced 0 while i_HBLANK_n=0; FSM keeps running in blank (prefetches first group).
//  i_ROM_RDY outside WAIT ignored. o_UNDERRUN clears only on reset.
// CONFIGURATION
//  BG_TILE_FLIP_EN defined: hflip/vflip attr bits honoured as above.
//  Not defined: attr[5:4] ignored, row=V[3:0], shift always MSB-first; no flip logic synthesised.
// STRUCTURE
//  Package bg_tile_pkg: FSM state enum, attr bit-position constants, ROM_AW/VRAM_AW defaults, GROUP_PIX=8.
//  Sub-module bg_pixel_shifter: 32-bit load/shift register with flip direction, blank masking, palette reg.
// TESTING
//  Scroll 0, code=0x12 attr=0x07 at tile (0,1), ROM word 0x12345678 -> VRAM addr 0x002/0x003, ROM addr {0,0x12,row,0}, pixels 1..8 pal 7.
//  H=0x1FB (carry=1,sum=0xFB) -> NH=0x003 wraps; VRAM addr uses NH[8:4]=0.
//  Withhold i_ROM_RDY past phase 7 -> o_PIXEL=0 for that group, o_UNDERRUN=1, RDY arriving later ignored.
//  attr=0x30 with BG_TILE_FLIP_EN, V[3:0]=2, word 0x12345678 -> row 13, pixels 8..1; without macro row 2, pixels 1..8.
//  Assert reset while o_ROM_RD=1 -> o_ROM_RD and all outputs 0 same edge; clean fetch resumes at next phase 1.
//  i_HBLANK_n=0 with valid data -> o_PIXEL=0, o_PALETTE=0; first visible group shows prefetched data.

Source files
------------

// File: rtl/bg_tile_pkg.sv
// ============================================================================
// Module      : bg_tile_pkg
// Description : Shared types and constants for the background tile fetcher.
//               The BG_TILE_FLIP_EN macro selects the flip-capable build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bg_tile_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CODE = 3'd1,
      ST_ATTR = 3'd2,
      ST_REQ  = 3'd3,
      ST_WAIT = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam int ATTR_CODE_HI = 7;
   localparam int ATTR_CODE_LO = 6;
   localparam int ATTR_HFLIP   = 5;
   localparam int ATTR_VFLIP   = 4;
   localparam int ATTR_PAL_HI  = 3;

   localparam int ROM_AW_DEF  = 15;
   localparam int VRAM_AW_DEF = 11;
   localparam int GROUP_PIX   = 8;

   // Position of the group being prefetched, wrapping in the 9-bit H space.
   function automatic logic [8:0] next_group_h(input logic [8:0] h);
      return h + 9'(GROUP_PIX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bg_pixel_shifter.sv
// ============================================================================
// Module      : bg_pixel_shifter
// Description : 32-bit pattern shifter with flip direction, palette register
//               and blank masking. hflip_i is tied low by the top when
//               BG_TILE_FLIP_EN is undefined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_pixel_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   input  logic [3:0]  palette_i,
   input  logic        hflip_i,
   input  logic        hblank_n_i,
   output logic [3:0]  pixel_o,
   output logic [3:0]  palette_o
);

   logic [31:0] sh_q, sh_d;
   logic        flip_q, flip_d;
   logic [3:0]  pal_q, pal_d;
   logic [3:0]  pix_q, pix_d;
   logic [3:0]  palo_q, palo_d;
   logic [31:0] w_src;

   // The loaded word's first pixel is presented on the load edge itself.
   always_comb begin
      sh_d   = sh_q;
      flip_d = flip_q;
      pal_d  = pal_q;
      pix_d  = pix_q;
      palo_d = palo_q;
      w_src  = sh_q;
      if (pix_en_i) begin
         if (load_i) begin
            flip_d = hflip_i;
            pal_d  = palette_i;
            w_src  = word_i;
         end
         pix_d  = flip_d ? w_src[3:0] : w_src[31:28];
         sh_d   = flip_d ? (w_src >> 4) : (w_src << 4);
         palo_d = pal_d;
      end
      if (!hblank_n_i) begin
         pix_d  = 4'd0;
         palo_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         flip_q <= 1'b0;
         pal_q  <= '0;
         pix_q  <= '0;
         palo_q <= '0;
      end else begin
         sh_q   <= sh_d;
         flip_q <= flip_d;
         pal_q  <= pal_d;
         pix_q  <= pix_d;
         palo_q <= palo_d;
      end
   end

   assign pixel_o   = pix_q;
   assign palette_o = palo_q;

endmodule

`default_nettype wire

// File: rtl/bg_tile_fetcher.sv
// ============================================================================
// Module      : bg_tile_fetcher
// Description : Background tile fetch sequencer, one 8-pixel group ahead of
//               display. Define BG_TILE_FLIP_EN to honour attr h/v flip bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_tile_fetcher
   import bg_tile_pkg::*;
#(
   parameter int ROM_AW  = ROM_AW_DEF,
   parameter int VRAM_AW = VRAM_AW_DEF
) (
   input  logic               i_EMU_MCLK,
   input  logic               i_EMU_INITRST_n,
   input  logic               i_EMU_CLK6MPCEN_n,
   input  logic [7:0]         i_HSUM,
   input  logic               i_HCARRY,
   input  logic [7:0]         i_VSUM,
   input  logic               i_VCARRY,
   input  logic               i_HBLANK_n,
   output logic [VRAM_AW-1:0] o_VRAM_ADDR,
   input  logic [7:0]         i_VRAM_DATA,
   output logic               o_ROM_RD,
   output logic [ROM_AW-1:0]  o_ROM_ADDR,
   input  logic               i_ROM_RDY,
   input  logic [31:0]        i_ROM_DATA,
   output logic [3:0]         o_PIXEL,
   output logic [3:0]         o_PALETTE,
   output logic               o_UNDERRUN
);

   state_t              state_q;
   logic [VRAM_AW-1:0]  vram_addr_q;
   logic                rom_rd_q;
   logic [ROM_AW-1:0]   rom_addr_q;
   logic [7:0]          code_q;
   logic [7:0]          attr_q;
   logic [31:0]         buf_q;
   logic                underrun_q;

   logic                w_pix_en;
   logic [2:0]          w_phase;
   logic [8:0]          w_h;
   logic [8:0]          w_v;
   logic [8:0]          w_nh;
   logic                w_boundary;
   logic [3:0]          w_row;
   logic                w_hflip;
   logic [31:0]         w_load_word;

   assign w_pix_en   = ~i_EMU_CLK6MPCEN_n;
   assign w_phase    = i_HSUM[2:0];
   assign w_h        = {i_HCARRY, i_HSUM};
   assign w_v        = {i_VCARRY, i_VSUM};
   assign w_nh       = next_group_h(w_h);
   assign w_boundary = w_pix_en && (w_phase == 3'd7);

`ifdef BG_TILE_FLIP_EN
   assign w_row   = w_v[3:0] ^ {4{attr_q[ATTR_VFLIP]}};
   assign w_hflip = attr_q[ATTR_HFLIP];
`else
   logic w_unused_flip;
   assign w_unused_flip = ^attr_q[ATTR_HFLIP:ATTR_VFLIP];
   assign w_row         = w_v[3:0];
   assign w_hflip       = 1'b0;
`endif

   // A group that never reached DONE is shown as transparent.
   assign w_load_word = (state_q == ST_DONE) ? buf_q : 32'd0;

   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
      if (!i_EMU_INITRST_n) begin
         state_q     <= ST_IDLE;
         vram_addr_q <= '0;
         rom_rd_q    <= 1'b0;
         rom_addr_q  <= '0;
         code_q      <= '0;
         attr_q      <= '0;
         buf_q       <= '0;
         underrun_q  <= 1'b0;
      end else if (w_boundary) begin
         state_q  <= ST_IDLE;
         rom_rd_q <= 1'b0;
         if (state_q != ST_DONE) begin
            underrun_q <= 1'b1;
         end
      end else if (w_pix_en && (w_phase == 3'd1)) begin
         // Unconditional restart keeps the sequencer aligned after scroll jumps.
         state_q     <= ST_CODE;
         rom_rd_q    <= 1'b0;
         vram_addr_q <= VRAM_AW'({w_v[8:4], w_nh[8:4], 1'b0});
      end else begin
         case (state_q)
            ST_CODE: begin
               if (w_pix_en && (w_phase == 3'd2)) begin
                  code_q         <= i_VRAM_DATA;
                  vram_addr_q[0] <= 1'b1;
                  state_q        <= ST_ATTR;
               end
            end
            ST_ATTR: begin
               if (w_pix_en && (w_phase == 3'd3)) begin
                  attr_q  <= i_VRAM_DATA;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               rom_rd_q   <= 1'b1;
               rom_addr_q <= ROM_AW'({attr_q[ATTR_CODE_HI:ATTR_CODE_LO], code_q,
                                      w_row, w_nh[3]});
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_ROM_RDY) begin
                  buf_q    <= i_ROM_DATA;
                  rom_rd_q <= 1'b0;
                  state_q  <= ST_DONE;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   bg_pixel_shifter u_shifter (
      .clk        (i_EMU_MCLK),
      .rst_n      (i_EMU_INITRST_n),
      .pix_en_i   (w_pix_en),
      .load_i     (w_boundary),
      .word_i     (w_load_word),
      .palette_i  (attr_q[ATTR_PAL_HI:0]),
      .hflip_i    (w_hflip),
      .hblank_n_i (i_HBLANK_n),
      .pixel_o    (o_PIXEL),
      .palette_o  (o_PALETTE)
   );

   assign o_VRAM_ADDR = vram_addr_q;
   assign o_ROM_RD    = rom_rd_q;
   assign o_ROM_ADDR  = rom_addr_q;
   assign o_UNDERRUN  = underrun_q;

endmodule

`default_nettype wire
